mem_tag_remap: RTL
==================

Name: mem_tag_remap

Overview:
Sits between the GPU top-level memory port (L3 output) and the external memory controller. It compresses the wide GPU memory tag into a small transaction ID, so the external fabric only tracks NUM_IDS outstanding reads. The original tag is held in an on-chip table and restored on the response. Writes pass through without an ID allocation, because memory returns no write responses.

Parameters:
ADDR_WIDTH, 26, line-address width
DATA_WIDTH, 512, line data width
TAG_IN_WIDTH, 40, GPU-side tag width
NUM_IDS, 16, max outstanding reads (power of two, >=2)
ID_WIDTH, log2(NUM_IDS), derived, external tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_req_valid  in  1  GPU request valid
in_req_rw  in  1  1=write
in_req_byteen  in  DATA_WIDTH/8  byte enables
in_req_addr  in  ADDR_WIDTH  line address
in_req_data  in  DATA_WIDTH  write data
in_req_tag  in  TAG_IN_WIDTH  GPU tag
in_req_ready  out  1  request accepted
in_rsp_valid  out  1  response to GPU
in_rsp_data  out  DATA_WIDTH  read data
in_rsp_tag  out  TAG_IN_WIDTH  restored tag
in_rsp_ready  in  1  GPU accepts response
out_req_valid / rw / byteen / addr / data  out  as in_req_*  to memory
out_req_tag  out  ID_WIDTH  allocated ID (0 for writes)
out_req_ready  in  1  memory accepts request
out_rsp_valid  in  1  memory response valid
out_rsp_data  in  DATA_WIDTH  read data
out_rsp_tag  in  ID_WIDTH  ID of response
out_rsp_ready  out  1  response accepted
pending  out  ID_WIDTH+1  outstanding read count
busy  out  1  pending != 0
err_unalloc  out  1  sticky: response arrived for a free ID

Behaviour:
- Reset state: all IDs free, pending=0, err_unalloc=0, tag table contents don't-care.
- During reset, in_req_ready=0, out_req_valid=0 and in_rsp_valid=0.
- Request path is combinational, with zero added latency:
  - out_req_* = in_req_*.
  - Write: out_req_valid=in_req_valid, in_req_ready=out_req_ready.
  - Read: out_req_valid = in_req_valid & has_free; in_req_ready = out_req_ready & has_free.
- Allocation: the lowest-index free ID drives out_req_tag.
- On read fire, the ID is marked allocated and table[ID] <= in_req_tag at the clock edge.
- Full (no free IDs): reads stall with no valid asserted toward memory; writes still flow.
- Response path is combinational:
  - in_rsp_tag = table[out_rsp_tag]; in_rsp_data = out_rsp_data.
  - If the ID is allocated: in_rsp_valid=out_rsp_valid and out_rsp_ready=in_rsp_ready.
  - On fire, the ID is freed at the clock edge.
- Unallocated ID (e.g. a stale response after reset mid-operation):
  - out_rsp_ready=1 and in_rsp_valid=0; the beat is dropped.
  - err_unalloc is set (sticky until reset); a simulation assertion fires.
- Simultaneous read alloc and response free in one cycle: both apply.
  - pending is unchanged.
  - The freed ID becomes allocatable only next cycle (registered free mask).
  - Same-ID alloc/free in one cycle is therefore impossible.
- pending counts +1 per read fire and −1 per valid response fire. It saturates nowhere; it is bounded by NUM_IDS by construction.
- Reset mid-operation: the free mask is cleared to all-free. In-flight memory responses are later absorbed as unallocated.
- Ordering: no reordering is imposed; responses return in memory order.

Decomposition:
- Shared package mem_tag_remap_pkg holds:
  - the req/rsp packed struct typedefs (rw, byteen, addr, data, tag);
  - the ID_WIDTH derivation function.
- Sub-module tag_free_list, covering:
  - the NUM_IDS-bit allocated mask;
  - a lowest-index priority encoder;
  - alloc/free strobes and the has_free output;
  - the pending counter.
- The tag table is a flop array with NUM_IDS entries of TAG_IN_WIDTH bits, with async read inside mem_tag_remap.

Test Plan:
- Reset, then 3 reads with tags 0xA1, 0xA2, 0xA3 and out_req_ready=1 -> out_req_tag 0,1,2; pending=3; busy=1.
- Memory returns ID 1 then ID 0 -> in_rsp_tag 0xA2 then 0xA1; pending=1.
- Issue 16 reads without responses -> 17th read sees in_req_ready=0 and out_req_valid=0. An interleaved write (rw=1) still fires with out_req_tag=0.
- At full, a response frees ID 5 in the same cycle as a pending read -> no alloc that cycle; next cycle the read fires with ID 5.
- in_rsp_ready=0 while out_rsp_valid=1 -> out_rsp_ready=0, the ID stays allocated, and the data is held until ready.
- Reset with 4 reads outstanding, then memory returns ID 2 -> the beat is consumed, in_rsp_valid=0, err_unalloc=1, pending=0.

Source files
------------

// File: rtl/mem_tag_remap_pkg.sv
// Shared types and helpers for the memory tag remapper.
// - Defines the request and response bundles at the product line configuration.
// - id_width(): the number of bits needed to index n transaction IDs (minimum 1).
package mem_tag_remap_pkg;

    localparam int MTR_ADDR_WIDTH   = 26;
    localparam int MTR_DATA_WIDTH   = 512;
    localparam int MTR_TAG_IN_WIDTH = 40;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

    typedef struct packed {
        logic                          rw;
        logic [MTR_DATA_WIDTH/8-1:0]   byteen;
        logic [MTR_ADDR_WIDTH-1:0]     addr;
        logic [MTR_DATA_WIDTH-1:0]     data;
        logic [MTR_TAG_IN_WIDTH-1:0]   tag;
    } mem_req_t;

    typedef struct packed {
        logic [MTR_DATA_WIDTH-1:0]     data;
        logic [MTR_TAG_IN_WIDTH-1:0]   tag;
    } mem_rsp_t;

endpackage

// File: rtl/mem_tag_remap_free_list.sv
// tag_free_list: tracks which transaction IDs are in flight.
// Ports:
//   clk, reset       - clock, synchronous active-high reset (all IDs free)
//   i_alloc          - allocate o_alloc_id this cycle
//   i_free/i_free_id - release an allocated ID this cycle
//   o_has_free       - at least one ID is free
//   o_alloc_id       - lowest-index free ID
//   o_alloc_mask     - registered allocated mask (bit set = in flight)
//   o_pending        - number of allocated IDs
module tag_free_list #(
    parameter int NUM_IDS  = 16,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_alloc,
    input  logic                i_free,
    input  logic [ID_WIDTH-1:0] i_free_id,
    output logic                o_has_free,
    output logic [ID_WIDTH-1:0] o_alloc_id,
    output logic [NUM_IDS-1:0]  o_alloc_mask,
    output logic [ID_WIDTH:0]   o_pending
);

    logic [NUM_IDS-1:0] r_mask;
    logic [ID_WIDTH:0]  r_pending;
    logic [ID_WIDTH-1:0] w_id;

    // Scan downward so the last hit is the lowest free index. Only the
    // registered mask is used, so an ID freed this cycle is not offered
    // until the next one.
    always_comb begin
        w_id = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--)
            if (!r_mask[i]) w_id = ID_WIDTH'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask    <= '0;
            r_pending <= '0;
        end else begin
            if (i_alloc) r_mask[w_id]      <= 1'b1;
            if (i_free)  r_mask[i_free_id] <= 1'b0;
            if (i_alloc && !i_free)
                r_pending <= r_pending + 1'b1;
            else if (i_free && !i_alloc)
                r_pending <= r_pending - 1'b1;
        end
    end

    assign o_has_free   = ~&r_mask;
    assign o_alloc_id   = w_id;
    assign o_alloc_mask = r_mask;
    assign o_pending    = r_pending;

endmodule

// File: rtl/mem_tag_remap.sv
// mem_tag_remap: compresses the wide GPU memory tag into a small transaction
// ID toward the memory controller and restores it on read responses.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_req_*  / in_rsp_* - GPU side request (in) and response (out)
//   out_req_* / out_rsp_*- memory side request (out) and response (in)
//   pending, busy        - outstanding read count, pending != 0
//   err_unalloc          - sticky: a response arrived for a free ID
// Writes bypass allocation (memory never answers them) and carry ID 0.
module mem_tag_remap
    import mem_tag_remap_pkg::*;
#(
    parameter int ADDR_WIDTH     = MTR_ADDR_WIDTH,
    parameter int DATA_WIDTH     = MTR_DATA_WIDTH,
    parameter int TAG_IN_WIDTH   = MTR_TAG_IN_WIDTH,
    parameter int NUM_IDS        = 16,
    parameter bit ASSERT_UNALLOC = 1'b1,
    localparam int ID_WIDTH      = id_width(NUM_IDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_req_valid,
    input  logic                    in_req_rw,
    input  logic [DATA_WIDTH/8-1:0] in_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   in_req_addr,
    input  logic [DATA_WIDTH-1:0]   in_req_data,
    input  logic [TAG_IN_WIDTH-1:0] in_req_tag,
    output logic                    in_req_ready,
    output logic                    in_rsp_valid,
    output logic [DATA_WIDTH-1:0]   in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0] in_rsp_tag,
    input  logic                    in_rsp_ready,
    output logic                    out_req_valid,
    output logic                    out_req_rw,
    output logic [DATA_WIDTH/8-1:0] out_req_byteen,
    output logic [ADDR_WIDTH-1:0]   out_req_addr,
    output logic [DATA_WIDTH-1:0]   out_req_data,
    output logic [ID_WIDTH-1:0]     out_req_tag,
    input  logic                    out_req_ready,
    input  logic                    out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   out_rsp_data,
    input  logic [ID_WIDTH-1:0]     out_rsp_tag,
    output logic                    out_rsp_ready,
    output logic [ID_WIDTH:0]       pending,
    output logic                    busy,
    output logic                    err_unalloc
);

    mem_req_t                 w_req;
    mem_rsp_t                 w_rsp;
    logic                     w_has_free;
    logic [ID_WIDTH-1:0]      w_alloc_id;
    logic [NUM_IDS-1:0]       w_mask;
    logic                     w_can_go;
    logic                     w_rd_fire;
    logic                     w_rsp_alloc;
    logic                     w_rsp_fire;
    logic [TAG_IN_WIDTH-1:0]  r_tag_tab [NUM_IDS];
    logic                     r_err;

    assign w_req = '{rw: in_req_rw, byteen: in_req_byteen, addr: in_req_addr,
                     data: in_req_data, tag: in_req_tag};

    // Request path: straight wires, reads additionally need a free ID.
    assign w_can_go       = !reset && (w_req.rw || w_has_free);
    assign out_req_valid  = in_req_valid && w_can_go;
    assign in_req_ready   = out_req_ready && w_can_go;
    assign out_req_rw     = w_req.rw;
    assign out_req_byteen = w_req.byteen;
    assign out_req_addr   = w_req.addr;
    assign out_req_data   = w_req.data;
    assign out_req_tag    = w_req.rw ? '0 : w_alloc_id;
    assign w_rd_fire      = in_req_valid && in_req_ready && !w_req.rw;

    // Response path: a beat for a free ID is swallowed and flagged.
    assign w_rsp_alloc   = w_mask[out_rsp_tag];
    assign w_rsp.data    = out_rsp_data;
    assign w_rsp.tag     = r_tag_tab[out_rsp_tag];
    assign in_rsp_data   = w_rsp.data;
    assign in_rsp_tag    = w_rsp.tag;
    assign in_rsp_valid  = !reset && out_rsp_valid && w_rsp_alloc;
    assign out_rsp_ready = w_rsp_alloc ? in_rsp_ready : 1'b1;
    assign w_rsp_fire    = in_rsp_valid && in_rsp_ready;

    tag_free_list #(
        .NUM_IDS  (NUM_IDS),
        .ID_WIDTH (ID_WIDTH)
    ) u_free_list (
        .clk          (clk),
        .reset        (reset),
        .i_alloc      (w_rd_fire),
        .i_free       (w_rsp_fire),
        .i_free_id    (out_rsp_tag),
        .o_has_free   (w_has_free),
        .o_alloc_id   (w_alloc_id),
        .o_alloc_mask (w_mask),
        .o_pending    (pending)
    );

    // Table contents are meaningless while the matching mask bit is clear,
    // so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_rd_fire) r_tag_tab[w_alloc_id] <= w_req.tag;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (out_rsp_valid && !w_rsp_alloc)
            r_err <= 1'b1;
    end

    assign busy        = |pending;
    assign err_unalloc = r_err;

    if (ASSERT_UNALLOC) begin : g_unalloc_chk
        always_ff @(posedge clk) begin
            assert (reset || !(out_rsp_valid && !w_rsp_alloc))
                else $error("response for unallocated id %0d", out_rsp_tag);
        end
    end

endmodule
